// File: rtl/mem_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and constants for the memory read-channel arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic       OWNER_IFU = 1'b0;
  localparam logic       OWNER_LSU = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage
`default_nettype wire

// File: rtl/mem_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_rd_arbiter_if
// Brief  : AXI4-Lite-style read channel (AR + R) bundle with master/slave views.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_rd_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/mem_rd_arbiter_arb_pick2.sv
`default_nettype none
// ============================================================================
// Module : arb_pick2
// Brief  : Two-way winner select; LSU-over-IFU fixed priority, or round-robin
//          on ties when ARB_RR_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module arb_pick2 (
  input  logic req_ifu,
  input  logic req_lsu,
`ifdef ARB_RR_EN
  input  logic last_lsu,
`endif
  output logic any_req,
  output logic pick_lsu
);

  assign any_req = req_ifu | req_lsu;

`ifdef ARB_RR_EN
  // On a tie the master that did not win last time goes first.
  assign pick_lsu = req_lsu & (~req_ifu | ~last_lsu);
`else
  assign pick_lsu = req_lsu;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_rd_arbiter
// Brief  : Two-master (IFU, LSU) to one-slave read-channel arbiter, one
//          outstanding read. Optional macro ARB_RR_EN selects round-robin ties.
// Rev    : 1.0  initial release
// ============================================================================
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_rd_arbiter_if.slave  ifu,
  mem_rd_arbiter_if.slave  lsu,
  mem_rd_arbiter_if.master mem,
  output logic             arb_busy
);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic          arvalid_q, arvalid_d;
`ifdef ARB_RR_EN
  logic          last_q, last_d;
`endif

  logic any_req;
  logic pick_lsu;
  logic grant;
  logic in_data;
  logic owner_rready;
  logic ifu_sel;
  logic lsu_sel;

  arb_pick2 u_pick (
    .req_ifu  (ifu.arvalid),
    .req_lsu  (lsu.arvalid),
`ifdef ARB_RR_EN
    .last_lsu (last_q),
`endif
    .any_req  (any_req),
    .pick_lsu (pick_lsu)
  );

  // Grants are suppressed during reset so no master sees an arready that is dropped.
  assign grant        = (state_q == ARB_IDLE) & any_req & ~rst;
  assign in_data      = (state_q == ARB_DATA);
  assign owner_rready = (owner_q == OWNER_LSU) ? lsu.rready : ifu.rready;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
`ifdef ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d   = ARB_ADDR;
          owner_d   = pick_lsu ? OWNER_LSU : OWNER_IFU;
          araddr_d  = pick_lsu ? lsu.araddr : ifu.araddr;
          arvalid_d = 1'b1;
`ifdef ARB_RR_EN
          last_d    = pick_lsu;
`endif
        end
      end
      ARB_ADDR: begin
        if (mem.arready) begin
          state_d   = ARB_DATA;
          arvalid_d = 1'b0;
        end
      end
      ARB_DATA: begin
        if (mem.rvalid && owner_rready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_IFU;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
`ifdef ARB_RR_EN
      last_q    <= OWNER_LSU;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
`ifdef ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign ifu.arready = grant & ~pick_lsu;
  assign lsu.arready = grant & pick_lsu;

  assign mem.araddr  = araddr_q;
  assign mem.arvalid = arvalid_q;
  assign mem.rready  = in_data & owner_rready;

  // R is a pure pass-through to the owner; the other master sees an idle channel.
  assign ifu_sel     = in_data & (owner_q == OWNER_IFU);
  assign lsu_sel     = in_data & (owner_q == OWNER_LSU);

  assign ifu.rvalid  = ifu_sel & mem.rvalid;
  assign ifu.rdata   = ifu_sel ? mem.rdata : {DW{1'b0}};
  assign ifu.rresp   = ifu_sel ? mem.rresp : RESP_OKAY;
  assign lsu.rvalid  = lsu_sel & mem.rvalid;
  assign lsu.rdata   = lsu_sel ? mem.rdata : {DW{1'b0}};
  assign lsu.rresp   = lsu_sel ? mem.rresp : RESP_OKAY;

  assign arb_busy    = (state_q != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_rd_arbiter
// Brief  : Self-checking bench for mem_rd_arbiter with a cycle-level reference
//          model, a reactive memory slave and randomized masters.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_rd_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic arb_busy;

  mem_rd_arbiter_if #(.AW(32), .DW(32)) ifu_bus ();
  mem_rd_arbiter_if #(.AW(32), .DW(32)) lsu_bus ();
  mem_rd_arbiter_if #(.AW(32), .DW(32)) mem_bus ();

  mem_rd_arbiter #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ifu      (ifu_bus),
    .lsu      (lsu_bus),
    .mem      (mem_bus),
    .arb_busy (arb_busy)
  );

  // master-side drive (index 0 = IFU, 1 = LSU)
  logic        arv_m [2];
  logic [31:0] ara_m [2];
  logic        rrd_m [2];
  // slave-side drive
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  assign ifu_bus.arvalid = arv_m[0];
  assign ifu_bus.araddr  = ara_m[0];
  assign ifu_bus.rready  = rrd_m[0];
  assign lsu_bus.arvalid = arv_m[1];
  assign lsu_bus.araddr  = ara_m[1];
  assign lsu_bus.rready  = rrd_m[1];
  assign mem_bus.arready = s_arready;
  assign mem_bus.rvalid  = s_rvalid;
  assign mem_bus.rdata   = s_rdata;
  assign mem_bus.rresp   = s_rresp;

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  logic        rst_req;
  int          ar_min, ar_max, r_min, r_max, eager_pct;
  int          rready_pct [2];
  bit          rready_hold_low [2];
  bit          spurious;
  logic [31:0] req_q0 [$];
  logic [31:0] req_q1 [$];
  bit          hs_ar [2];
  int          grant_log [$];
  int          rx_cnt [2];
  logic [31:0] last_rx [2];
  // outstanding transaction as seen from the masters
  bit          iss_valid;
  int          iss_who;
  logic [31:0] iss_addr;
  // slave state
  int          s_phase, s_cnt;
  logic [31:0] s_addr;
  // reference model of the arbiter
  bit          md_busy, md_data, md_own, md_last;
  logic [31:0] md_addr;

  function automatic logic [31:0] fdata(logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  function automatic bit req_empty(int i);
    return (i == 1) ? (req_q1.size() == 0) : (req_q0.size() == 0);
  endfunction

  function automatic logic [31:0] req_front(int i);
    return (i == 1) ? req_q1[0] : req_q0[0];
  endfunction

  task automatic req_pop(int i);
    if (i == 1) void'(req_q1.pop_front());
    else        void'(req_q0.pop_front());
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_and_update();
    bit          win_lsu, grant, own_rr, sel, hs_r;
    logic        act_arr [2];
    logic        act_rv  [2];
    logic [31:0] act_rd  [2];
    logic [1:0]  act_rs  [2];
    act_arr[0] = ifu_bus.arready; act_arr[1] = lsu_bus.arready;
    act_rv[0]  = ifu_bus.rvalid;  act_rv[1]  = lsu_bus.rvalid;
    act_rd[0]  = ifu_bus.rdata;   act_rd[1]  = lsu_bus.rdata;
    act_rs[0]  = ifu_bus.rresp;   act_rs[1]  = lsu_bus.rresp;

    // tie: fixed build -> LSU; round-robin -> whoever did not win last
    win_lsu = arv_m[1] && (!arv_m[0] || (RR ? !md_last : 1'b1));
    grant   = !md_busy && (arv_m[0] || arv_m[1]) && !rst;
    own_rr  = md_own ? rrd_m[1] : rrd_m[0];

    chk("arb_busy", 32'(arb_busy), 32'(md_busy));
    chk("mem_araddr", mem_bus.araddr, md_addr);
    chk("mem_arvalid", 32'(mem_bus.arvalid), 32'(md_busy && !md_data));
    chk("mem_rready", 32'(mem_bus.rready), 32'(md_data && own_rr));
    for (int i = 0; i < 2; i++) begin
      sel = md_data && (int'(md_own) == i);
      chk($sformatf("arready%0d", i), 32'(act_arr[i]), 32'(grant && (win_lsu == (i == 1))));
      chk($sformatf("rvalid%0d", i), 32'(act_rv[i]), 32'(sel && s_rvalid));
      chk($sformatf("rdata%0d", i), act_rd[i], sel ? s_rdata : 32'h0);
      chk($sformatf("rresp%0d", i), 32'(act_rs[i]), sel ? 32'(s_rresp) : 32'h0);
    end

    // end-to-end scoreboard: each beat must carry data for that master's own address
    for (int i = 0; i < 2; i++) begin
      if (act_rv[i] && rrd_m[i]) begin
        chk("r_outstanding", 32'(iss_valid), 32'h1);
        chk("r_owner", 32'(i), 32'(iss_who));
        chk("r_data", act_rd[i], fdata(iss_addr));
        chk("r_resp", 32'(act_rs[i]), 32'(iss_addr[5:4]));
        rx_cnt[i]++;
        last_rx[i] = act_rd[i];
        iss_valid  = 1'b0;
      end
    end
    hs_r = s_rvalid && mem_bus.rready;
    if (s_phase == 2 && hs_r) s_phase = 0;
    if (mem_bus.arvalid && s_arready && s_phase == 1) begin
      s_phase = 2;
      s_addr  = mem_bus.araddr;
      s_cnt   = $urandom_range(r_max, r_min);
    end
    for (int i = 0; i < 2; i++) begin
      if (arv_m[i] && act_arr[i]) begin
        iss_valid = 1'b1;
        iss_who   = i;
        iss_addr  = ara_m[i];
        req_pop(i);
        hs_ar[i]  = 1'b1;
        grant_log.push_back(i);
      end
    end

    if (rst) begin
      md_busy = 0; md_data = 0; md_own = 0; md_last = 1; md_addr = '0;
      s_phase = 0; iss_valid = 0; hs_ar[0] = 0; hs_ar[1] = 0;
    end else if (!md_busy) begin
      if (grant) begin
        md_busy = 1; md_own = win_lsu; md_last = win_lsu;
        md_addr = win_lsu ? ara_m[1] : ara_m[0];
      end
    end else if (!md_data) begin
      if (s_arready) md_data = 1;
    end else if (s_rvalid && own_rr) begin
      md_busy = 0; md_data = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_req;
    for (int i = 0; i < 2; i++) begin
      if (hs_ar[i]) begin
        arv_m[i] = 1'b0;
        hs_ar[i] = 1'b0;
      end else if (!arv_m[i] && !req_empty(i) && $urandom_range(99, 0) < 32'(eager_pct)) begin
        arv_m[i] = 1'b1;
        ara_m[i] = req_front(i);
      end
      rrd_m[i] = rready_hold_low[i] ? 1'b0 : ($urandom_range(99, 0) < 32'(rready_pct[i]));
    end
    if (s_phase == 0 && mem_bus.arvalid) begin
      s_cnt   = $urandom_range(ar_max, ar_min);
      s_phase = 1;
    end
    s_arready = 1'b0;
    if (s_phase == 1) begin
      s_arready = (s_cnt == 0);
      if (s_cnt != 0) s_cnt--;
    end
    if (s_phase == 2 && s_cnt == 0) begin
      s_rvalid = 1'b1;
      s_rdata  = fdata(s_addr);
      s_rresp  = s_addr[5:4];
    end else begin
      if (s_phase == 2) s_cnt--;
      s_rvalid = spurious && (s_phase != 2) && ($urandom_range(3, 0) == 0);
      s_rdata  = $urandom;
      s_rresp  = 2'($urandom_range(3, 0));
    end
    @(negedge clk);
    check_and_update();
  endtask

  task automatic wait_done(int budget, string nm);
    bit done = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (req_empty(0) && req_empty(1) && !md_busy && !arv_m[0] && !arv_m[1] && !iss_valid) begin
        done = 1;
        break;
      end
    end
    chk(nm, 32'(done), 32'h1);
  endtask

  task automatic apply_reset();
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    int base;
    rst = 1'b1; rst_req = 1'b1;
    arv_m[0] = 0; arv_m[1] = 0; ara_m[0] = '0; ara_m[1] = '0; rrd_m[0] = 0; rrd_m[1] = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    ar_min = 0; ar_max = 0; r_min = 0; r_max = 2; eager_pct = 100;
    rready_pct[0] = 100; rready_pct[1] = 100;
    rready_hold_low[0] = 0; rready_hold_low[1] = 0; spurious = 0;
    hs_ar[0] = 0; hs_ar[1] = 0; rx_cnt[0] = 0; rx_cnt[1] = 0;
    last_rx[0] = '0; last_rx[1] = '0; iss_valid = 0; iss_who = 0; iss_addr = '0;
    s_phase = 0; s_cnt = 0; s_addr = '0;
    md_busy = 0; md_data = 0; md_own = 0; md_last = 1; md_addr = '0;

    apply_reset();
    chk("rst_busy", 32'(arb_busy), 32'h0);
    chk("rst_araddr", mem_bus.araddr, 32'h0);

    // 1: IFU-only read, slave accepts address after a fixed delay
    ar_min = 3; ar_max = 3;
    req_q0.push_back(32'h8000_0000);
    wait_done(200, "t1_done");
    chk("t1_ifu_rdata", last_rx[0], 32'h0000_0413);
    chk("t1_lsu_rx", 32'(rx_cnt[1]), 32'h0);

    // 2: simultaneous requests right after reset
    apply_reset();
    grant_log.delete();
    ar_min = 0; ar_max = 2;
    req_q0.push_back(32'h8000_0004);
    req_q1.push_back(32'h8000_1000);
    wait_done(200, "t2_done");
    chk("t2_grants", 32'(grant_log.size()), 32'h2);
    chk("t2_first", 32'(grant_log[0]), RR ? 32'h0 : 32'h1);
    chk("t2_second", 32'(grant_log[1]), RR ? 32'h1 : 32'h0);

    // 3: LSU withholds rready while data is waiting
    r_min = 0; r_max = 0; rready_hold_low[1] = 1;
    req_q1.push_back(32'h8000_2000);
    reached = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (md_data && s_rvalid) begin reached = 1; break; end
    end
    chk("t3_reach_data", 32'(reached), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_busy", 32'(arb_busy), 32'h1);
      chk("t3_mem_rready", 32'(mem_bus.rready), 32'h0);
      chk("t3_lsu_rdata", lsu_bus.rdata, fdata(32'h8000_2000));
    end
    rready_hold_low[1] = 0;
    wait_done(100, "t3_done");
    chk("t3_rx", last_rx[1], fdata(32'h8000_2000));

    // 4: reset while the address phase is pending
    ar_min = 10; ar_max = 10;
    req_q0.push_back(32'h8000_3000);
    reached = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (md_busy && !md_data) begin reached = 1; break; end
    end
    chk("t4_reach_addr", 32'(reached), 32'h1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("t4_busy", 32'(arb_busy), 32'h0);
    chk("t4_arvalid", 32'(mem_bus.arvalid), 32'h0);
    chk("t4_araddr", mem_bus.araddr, 32'h0);
    ar_min = 0; ar_max = 2;
    req_q0.push_back(32'h8000_3004);
    wait_done(200, "t4_done");
    chk("t4_rx", last_rx[0], fdata(32'h8000_3004));

    // 6: IFU drops arvalid right after its grant; latched address must persist
    ar_min = 4; ar_max = 4;
    req_q0.push_back(32'h8000_0100);
    reached = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (md_busy) begin reached = 1; break; end
    end
    chk("t6_granted", 32'(reached), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_araddr", mem_bus.araddr, 32'h8000_0100);
      chk("t6_arvalid", 32'(mem_bus.arvalid), 32'h1);
    end
    wait_done(100, "t6_done");
    chk("t6_rx", last_rx[0], fdata(32'h8000_0100));

    // 5: random back-to-back traffic from both masters
    ar_min = 0; ar_max = 31; r_min = 0; r_max = 31;
    rready_pct[0] = 70; rready_pct[1] = 70; eager_pct = 60; spurious = 1;
    base = rx_cnt[0] + rx_cnt[1];
    for (int k = 0; k < 50; k++) begin
      req_q0.push_back($urandom);
      req_q1.push_back($urandom);
    end
    wait_done(20000, "t5_done");
    chk("t5_rx", 32'(rx_cnt[0] + rx_cnt[1] - base), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
